// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin write arbiter that shares the single write port of a FIFO
// between R requesters. Each requester uses a valid/ready handshake. The
// winning beat is registered onto the FIFO write port one cycle after it is
// accepted. Occupancy is tracked here, including the write that is still in
// flight, so a beat is never issued into a full FIFO.
//
// Optional feature (compile-time macro FIFO_ARB_BURST_EN):
//   defined   - a winner keeps the port for up to BURST consecutive beats
//               (IDLE/OWN FSM). Releasing ownership costs one bubble cycle.
//   undefined - every accept re-arbitrates: one beat per grant, no bubbles.
//               BURST is ignored.
//
// Parameters:
//   N      data width per beat (same as the FIFO N)
//   R      number of requesters (>= 2)
//   M      FIFO depth (same as the FIFO M)
//   BURST  maximum consecutive beats per grant in burst mode (>= 1)
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset (FIFO gets rst_n = ~rst)
//   req         per-requester "beat pending"
//   data_in     flattened beats, requester i at [i*N +: N]
//   ready       one-hot combinational accept strobe
//   fifo_wr_en  registered FIFO write enable
//   fifo_data   registered FIFO write data
//   fifo_rd_en  tap of the consumer's FIFO rd_en
//   fifo_empty  FIFO status_empty
//   occupancy   reserved FIFO entries (stored + in-flight writes)
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int unsigned N     = 8,
  parameter int unsigned R     = 4,
  parameter int unsigned M     = 4,
  parameter int unsigned BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [R-1:0]       req,
  input  logic [R*N-1:0]     data_in,
  output logic [R-1:0]       ready,
  output logic               fifo_wr_en,
  output logic [N-1:0]       fifo_data,
  input  logic               fifo_rd_en,
  input  logic               fifo_empty,
  output logic [$clog2(M):0] occupancy
);

  localparam int unsigned IW = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned OW = $clog2(M) + 1;

  // An illegal parameter set elaborates to an arbiter that never grants,
  // rather than one that silently misbehaves.
  localparam bit CFG_OK = (R >= 2) && (BURST >= 1);

  // ---------------------------------------------------------------------------
  // State registers shared by both build variants
  // ---------------------------------------------------------------------------
  logic [IW-1:0] last_reg, last_next;
  logic [OW-1:0] occupancy_reg, occupancy_next;
  logic          wr_en_reg, wr_en_next;
  logic [N-1:0]  data_reg, data_next;

  // Arbitration results
  logic          accept;
  logic [IW-1:0] grant_idx;
  logic          space;
  logic          pop;

  // ---------------------------------------------------------------------------
  // Unflatten the beat bus
  // ---------------------------------------------------------------------------
  logic [N-1:0] beat [R];

  for (genvar gi = 0; gi < R; gi++) begin : g_beat
    assign beat[gi] = data_in[gi*N +: N];
  end

  // ---------------------------------------------------------------------------
  // Round-robin search. Slot gi of the rotated view holds requester
  // (last + 1 + gi) mod R, so the lowest set slot is the next winner.
  // The sum never exceeds 2R-1, so a single conditional subtract is the mod.
  // ---------------------------------------------------------------------------
  logic [IW-1:0] cand_idx [R];
  logic [R-1:0]  req_rot;

  for (genvar gi = 0; gi < R; gi++) begin : g_rot
    logic [IW:0] sum;
    assign sum          = {1'b0, last_reg} + (IW+1)'(gi + 1);
    assign cand_idx[gi] = (sum >= (IW+1)'(R)) ? IW'(sum - (IW+1)'(R)) : IW'(sum);
    assign req_rot[gi]  = req[cand_idx[gi]];
  end

  logic          rr_valid;
  logic [IW-1:0] rr_idx;

  // Walk from the far end so the nearest slot is the last one written.
  always_comb begin
    rr_valid = 1'b0;
    rr_idx   = '0;
    for (int k = R - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        rr_valid = 1'b1;
        rr_idx   = cand_idx[k];
      end
    end
  end

  // Space check uses the current occupancy only: an entry freed by a pop in
  // this cycle becomes grantable in the next one.
  assign space = (occupancy_reg < OW'(M));

  // The FIFO handles a push before a pop, so a read of an empty FIFO still
  // pops when the write in flight lands in the same cycle.
  assign pop = fifo_rd_en & (~fifo_empty | wr_en_reg);

`ifdef FIFO_ARB_BURST_EN
  // ---------------------------------------------------------------------------
  // Burst ownership FSM
  // ---------------------------------------------------------------------------
  localparam int unsigned CW = $clog2(BURST + 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] owner_reg, owner_next;
  logic [CW-1:0] count_reg, count_next;

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    count_next = count_reg;
    accept     = 1'b0;
    grant_idx  = rr_idx;

    case (state_reg)
      IDLE: begin
        if (space && rr_valid) begin
          accept     = 1'b1;
          state_next = OWN;
          owner_next = rr_idx;
          count_next = CW'(1);
        end
      end
      OWN: begin
        if (req[owner_reg] && (count_reg < CW'(BURST))) begin
          // Owner keeps the port; without space it simply stalls here.
          grant_idx = owner_reg;
          if (space) begin
            accept     = 1'b1;
            count_next = count_reg + CW'(1);
          end
        end else begin
          // Release costs one idle cycle; last already names the owner.
          state_next = IDLE;
          count_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase

    if (!CFG_OK || rst) begin
      accept = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      count_reg <= count_next;
    end
  end
`else
  // ---------------------------------------------------------------------------
  // Single-beat round-robin: every accept re-arbitrates.
  // ---------------------------------------------------------------------------
  always_comb begin
    accept    = CFG_OK && !rst && space && rr_valid;
    grant_idx = rr_idx;
  end
`endif

  // ---------------------------------------------------------------------------
  // Write port and occupancy
  // ---------------------------------------------------------------------------
  assign ready = accept ? (R'(1) << grant_idx) : '0;

  always_comb begin
    last_next      = last_reg;
    wr_en_next     = accept;
    data_next      = data_reg;
    occupancy_next = occupancy_reg + OW'(accept) - OW'(pop);
    if (accept) begin
      last_next = grant_idx;
      data_next = beat[grant_idx];
    end
  end

  // Reset also drops a beat accepted in the previous cycle; the FIFO resets
  // on the same edge, so both sides agree the entry never existed.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg      <= IW'(R - 1);
      occupancy_reg <= '0;
      wr_en_reg     <= 1'b0;
      data_reg      <= '0;
    end else begin
      last_reg      <= last_next;
      occupancy_reg <= occupancy_next;
      wr_en_reg     <= wr_en_next;
      data_reg      <= data_next;
    end
  end

  assign fifo_wr_en = wr_en_reg;
  assign fifo_data  = data_reg;
  assign occupancy  = occupancy_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Drives fifo_wr_arbiter with requester queues and a behavioural FIFO, and
// compares against a reference model of the arbitration rules. Build with
// +define+FIFO_ARB_BURST_EN to exercise burst ownership.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  localparam int N     = 8;
  localparam int R     = 4;
  localparam int M     = 4;
  localparam int BURST = 4;
  localparam int OW    = $clog2(M) + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [R-1:0]   req;
  logic [R*N-1:0] data_in;
  logic [R-1:0]   ready;
  logic           fifo_wr_en;
  logic [N-1:0]   fifo_data;
  logic           fifo_rd_en;
  logic           fifo_empty;
  logic [OW-1:0]  occupancy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N(N), .R(R), .M(M), .BURST(BURST)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .data_in    (data_in),
    .ready      (ready),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .fifo_empty (fifo_empty),
    .occupancy  (occupancy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Requester beat queues, FIFO contents, and expected write order
  logic [N-1:0] rq [R][$];
  logic [N-1:0] fq [$];
  logic [N-1:0] sb [$];

  // Reference model state
  int           m_occ  = 0;
  int           m_last = R - 1;
  bit           m_wr   = 1'b0;
  logic [N-1:0] m_data = '0;
`ifdef FIFO_ARB_BURST_EN
  bit           m_own   = 1'b0;
  int           m_owner = 0;
  int           m_cnt   = 0;
`endif

  // Per-cycle observations
  logic [R-1:0] exp_ready, obs_ready;
  bit           pop_seen;
  logic [N-1:0] pop_data, pop_exp;

  task automatic clear_reqs();
    for (int i = 0; i < R; i++) rq[i].delete();
  endtask

  // One clock cycle: apply inputs after the falling edge, predict the grant,
  // sample ready, advance through the rising edge, update model and FIFO,
  // and return at the next falling edge.
  task automatic drive_cycle(input bit r, input bit rd);
    bit           acc, space, pop, wr_now;
    int           g;
    logic [N-1:0] beat, data_now, tmp;
`ifdef FIFO_ARB_BURST_EN
    bit           release_own;
    release_own = 1'b0;
`endif
    rst        = r;
    fifo_rd_en = rd;
    fifo_empty = (fq.size() == 0);
    for (int i = 0; i < R; i++) begin
      req[i]            = (rq[i].size() > 0);
      data_in[i*N +: N] = (rq[i].size() > 0) ? rq[i][0] : '0;
    end

    acc   = 1'b0;
    g     = 0;
    beat  = '0;
    space = (m_occ < M);
    if (!r) begin
`ifdef FIFO_ARB_BURST_EN
      if (m_own) begin
        if (req[m_owner] && m_cnt < BURST) begin
          if (space) begin acc = 1'b1; g = m_owner; end
        end else begin
          release_own = 1'b1;
        end
      end else if (space) begin
        for (int k = 1; k <= R; k++)
          if (!acc && req[(m_last + k) % R]) begin acc = 1'b1; g = (m_last + k) % R; end
      end
`else
      if (space) begin
        for (int k = 1; k <= R; k++)
          if (!acc && req[(m_last + k) % R]) begin acc = 1'b1; g = (m_last + k) % R; end
      end
`endif
    end
    if (acc) beat = rq[g][0];
    exp_ready = '0;
    if (acc) exp_ready[g] = 1'b1;

    #1;
    obs_ready = ready;
    wr_now    = fifo_wr_en;
    data_now  = fifo_data;
    @(posedge clk);

    for (int i = 0; i < R; i++)
      if (req[i] && obs_ready[i]) tmp = rq[i].pop_front();

    pop_seen = 1'b0;
    if (r) begin
      m_occ  = 0;
      m_last = R - 1;
      m_wr   = 1'b0;
      m_data = '0;
`ifdef FIFO_ARB_BURST_EN
      m_own  = 1'b0;
      m_cnt  = 0;
`endif
      fq.delete();
      sb.delete();
    end else begin
      pop = rd && (fq.size() > 0 || m_wr);
      if (wr_now && fq.size() < M) fq.push_back(data_now);
      if (rd && fq.size() > 0) begin
        pop_seen = 1'b1;
        pop_data = fq.pop_front();
        if (sb.size() > 0) pop_exp = sb.pop_front();
        else               pop_exp = 'x;
      end
      m_occ = m_occ + int'(acc) - int'(pop);
      m_wr  = acc;
      if (acc) begin
        m_data = beat;
        m_last = g;
        sb.push_back(beat);
        $display("[%0t] beat: requester %0d data %h occ_before %0d", $time, g, beat, m_occ - 1 + int'(pop));
      end
`ifdef FIFO_ARB_BURST_EN
      if (acc) begin
        if (m_own) m_cnt++;
        else begin m_own = 1'b1; m_owner = g; m_cnt = 1; end
      end else if (release_own) begin
        m_own = 1'b0;
        m_cnt = 0;
      end
`endif
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_reqs();
    for (int i = 0; i < R; i++) rq[i].push_back(8'(i + 1));
    for (int c = 0; c < 2; c++) begin
      drive_cycle(1'b1, 1'b0);
      n_checks++;
      if (obs_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", obs_ready); end
    end
    n_checks++;
    if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
    n_checks++;
    if (fifo_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 00", fifo_data); end
    n_checks++;
    if (occupancy !== '0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    clear_reqs();
  endtask

`ifndef FIFO_ARB_BURST_EN
  task automatic test_round_robin();
    clear_reqs();
    drive_cycle(1'b1, 1'b0);
    for (int i = 0; i < R; i++) rq[i].push_back(8'(8'hA0 + i));
    for (int i = 0; i < R; i++) begin
      drive_cycle(1'b0, 1'b0);
      n_checks++;
      if (obs_ready !== 4'(1 << i)) begin n_fail++; $display("FAIL rr_ready%0d: got %b want %b", i, obs_ready, 4'(1 << i)); end
      n_checks++;
      if (fifo_wr_en !== 1'b1 || fifo_data !== 8'(8'hA0 + i)) begin
        n_fail++; $display("FAIL rr_write%0d: got en=%b data=%h want en=1 data=%h", i, fifo_wr_en, fifo_data, 8'(8'hA0 + i));
      end
      n_checks++;
      if (occupancy !== OW'(i + 1)) begin n_fail++; $display("FAIL rr_occ%0d: got %0d want %0d", i, occupancy, i + 1); end
    end
    rq[0].push_back(8'hC0);
    drive_cycle(1'b0, 1'b0);
    n_checks++;
    if (obs_ready !== '0) begin n_fail++; $display("FAIL rr_full_ready: got %b want 0000", obs_ready); end
    n_checks++;
    if (fifo_wr_en !== 1'b0 || occupancy !== OW'(M)) begin
      n_fail++; $display("FAIL rr_full_state: got en=%b occ=%0d want en=0 occ=%0d", fifo_wr_en, occupancy, M);
    end
  endtask
`endif

  task automatic test_full_pop();
    clear_reqs();
    drive_cycle(1'b1, 1'b0);
    for (int i = 0; i < M; i++) rq[0].push_back(8'(8'hD0 + i));
    for (int i = 0; i < M; i++) drive_cycle(1'b0, 1'b0);
    n_checks++;
    if (occupancy !== OW'(M)) begin n_fail++; $display("FAIL full_fill_occ: got %0d want %0d", occupancy, M); end
    rq[2].push_back(8'hB2);
    drive_cycle(1'b0, 1'b0);
    n_checks++;
    if (obs_ready !== '0 || occupancy !== OW'(M)) begin
      n_fail++; $display("FAIL full_hold: got ready=%b occ=%0d want ready=0000 occ=%0d", obs_ready, occupancy, M);
    end
    drive_cycle(1'b0, 1'b1);
    n_checks++;
    if (obs_ready !== '0 || occupancy !== OW'(M - 1)) begin
      n_fail++; $display("FAIL full_pop: got ready=%b occ=%0d want ready=0000 occ=%0d", obs_ready, occupancy, M - 1);
    end
    n_checks++;
    if (!pop_seen || pop_data !== 8'hD0) begin n_fail++; $display("FAIL full_pop_data: got seen=%b data=%h want seen=1 data=d0", pop_seen, pop_data); end
    drive_cycle(1'b0, 1'b0);
    n_checks++;
    if (obs_ready !== 4'b0100 || occupancy !== OW'(M)) begin
      n_fail++; $display("FAIL full_regrant: got ready=%b occ=%0d want ready=0100 occ=%0d", obs_ready, occupancy, M);
    end
    n_checks++;
    if (fifo_wr_en !== 1'b1 || fifo_data !== 8'hB2) begin
      n_fail++; $display("FAIL full_regrant_data: got en=%b data=%h want en=1 data=b2", fifo_wr_en, fifo_data);
    end
  endtask

  task automatic test_empty_pop();
    clear_reqs();
    drive_cycle(1'b1, 1'b0);
    rq[0].push_back(8'hE5);
    drive_cycle(1'b0, 1'b0);
    n_checks++;
    if (obs_ready !== 4'b0001 || fifo_wr_en !== 1'b1 || occupancy !== OW'(1)) begin
      n_fail++; $display("FAIL empty_accept: got ready=%b en=%b occ=%0d want ready=0001 en=1 occ=1", obs_ready, fifo_wr_en, occupancy);
    end
    drive_cycle(1'b0, 1'b1);
    n_checks++;
    if (occupancy !== '0) begin n_fail++; $display("FAIL empty_pop_occ: got %0d want 0", occupancy); end
    n_checks++;
    if (!pop_seen || pop_data !== 8'hE5) begin n_fail++; $display("FAIL empty_pop_data: got seen=%b data=%h want seen=1 data=e5", pop_seen, pop_data); end
    drive_cycle(1'b0, 1'b0);
    n_checks++;
    if (occupancy !== '0 || fifo_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL empty_settle: got occ=%0d en=%b want occ=0 en=0", occupancy, fifo_wr_en);
    end
  endtask

  task automatic test_reset_mid();
    clear_reqs();
    drive_cycle(1'b1, 1'b0);
    rq[1].push_back(8'h71);
    drive_cycle(1'b0, 1'b0);
    n_checks++;
    if (obs_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_first_grant: got %b want 0010", obs_ready); end
    rq[0].push_back(8'h70);
    rq[1].push_back(8'h72);
    drive_cycle(1'b1, 1'b0);
    n_checks++;
    if (obs_ready !== '0 || fifo_wr_en !== 1'b0 || occupancy !== '0) begin
      n_fail++; $display("FAIL mid_reset: got ready=%b en=%b occ=%0d want ready=0000 en=0 occ=0", obs_ready, fifo_wr_en, occupancy);
    end
    drive_cycle(1'b0, 1'b0);
    n_checks++;
    if (obs_ready !== 4'b0001 || fifo_data !== 8'h70) begin
      n_fail++; $display("FAIL mid_priority: got ready=%b data=%h want ready=0001 data=70", obs_ready, fifo_data);
    end
  endtask

`ifdef FIFO_ARB_BURST_EN
  task automatic test_burst();
    logic [R-1:0] exp_tab [11];
    exp_tab = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h0, 4'h2, 4'h2, 4'h0};
    clear_reqs();
    drive_cycle(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) rq[1].push_back(8'(8'h10 + i));
    rq[3].push_back(8'h30);
    rq[3].push_back(8'h31);
    for (int c = 0; c < 11; c++) begin
      drive_cycle(1'b0, 1'b1);
      n_checks++;
      if (obs_ready !== exp_tab[c]) begin n_fail++; $display("FAIL burst_cycle%0d: got %b want %b", c, obs_ready, exp_tab[c]); end
    end
  endtask
`endif

  task automatic test_random();
    clear_reqs();
    drive_cycle(1'b1, 1'b0);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < R; i++)
        if (rq[i].size() < 3 && $urandom_range(0, 2) == 0) rq[i].push_back(8'($urandom));
      drive_cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 4));
      n_checks++;
      if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", c, obs_ready, exp_ready); end
      n_checks++;
      if (fifo_wr_en !== m_wr) begin n_fail++; $display("FAIL rand_wr_en c%0d: got %b want %b", c, fifo_wr_en, m_wr); end
      n_checks++;
      if (fifo_data !== m_data) begin n_fail++; $display("FAIL rand_data c%0d: got %h want %h", c, fifo_data, m_data); end
      n_checks++;
      if (occupancy !== OW'(m_occ)) begin n_fail++; $display("FAIL rand_occ c%0d: got %0d want %0d", c, occupancy, m_occ); end
      if (pop_seen) begin
        n_checks++;
        if (pop_data !== pop_exp) begin n_fail++; $display("FAIL rand_read c%0d: got %h want %h", c, pop_data, pop_exp); end
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    req        = '0;
    data_in    = '0;
    fifo_rd_en = 1'b0;
    fifo_empty = 1'b1;
    test_reset();
`ifndef FIFO_ARB_BURST_EN
    test_round_robin();
`endif
    test_full_pop();
    test_empty_pop();
    test_reset_mid();
`ifdef FIFO_ARB_BURST_EN
    test_burst();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
